// File: rtl/id_hazard_ctrl_if.sv
// Signal bundle between the ID-stage pipeline datapath and the hazard controller.
// master = pipeline side (drives decode/EX/MEM info), slave = hazard controller.
interface id_hazard_ctrl_if #(parameter int STAT_W = 16);
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic              id_equal;
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [4:0]        ex_dst;
  logic              mem_mem_read;
  logic [4:0]        mem_dst;
  logic              hold_req;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              branch_taken;
  logic [1:0]        state;
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] branch_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_equal,
           ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst, hold_req,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
           state, stall_cnt, branch_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_equal,
           ex_mem_read, ex_reg_write, ex_dst, mem_mem_read, mem_dst, hold_req,
    output pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
           state, stall_cnt, branch_cnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/stall controller for the 5-stage MIPS pipeline (Mealy outputs, RUN/STALL/HOLD FSM).
// Optional stall/branch statistics counters are built only when HAZARD_STATS_EN is defined.
module id_hazard_ctrl #(
  parameter int STAT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  id_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q, state_d;
  logic   ret_stall_q, ret_stall_d;
  logic   uses_rs, uses_rt, is_beq;
  logic   ex_match, mem_match, need_two, need_one;
  logic   pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken;

  assign is_beq  = hz.id_valid && (hz.id_opcode == OP_BEQ);
  assign uses_rt = hz.id_valid && (hz.id_opcode == OP_RTYPE || hz.id_opcode == OP_SW ||
                                   hz.id_opcode == OP_BEQ);
  assign uses_rs = uses_rt || (hz.id_valid && hz.id_opcode == OP_LW);

  // Register $0 is hardwired to zero, so it never participates in a match.
  assign ex_match  = (uses_rs && hz.id_rs != 5'd0 && hz.id_rs == hz.ex_dst) ||
                     (uses_rt && hz.id_rt != 5'd0 && hz.id_rt == hz.ex_dst);
  assign mem_match = (uses_rs && hz.id_rs != 5'd0 && hz.id_rs == hz.mem_dst) ||
                     (uses_rt && hz.id_rt != 5'd0 && hz.id_rt == hz.mem_dst);

  assign need_two = is_beq && hz.ex_mem_read && ex_match;
  assign need_one = (hz.ex_mem_read && ex_match) ||
                    (is_beq && hz.ex_reg_write && ex_match) ||
                    (is_beq && hz.mem_mem_read && mem_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      ret_stall_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_stall_q <= ret_stall_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_stall_d  = ret_stall_q;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    branch_taken = 1'b0;

    // A hold arriving in HOLD must not overwrite the state saved on entry.
    if (hz.hold_req) begin
      state_d = HOLD;
      if (state_q != HOLD) ret_stall_d = (state_q == STALL);
    end else begin
      case (state_q)
        RUN:     if (need_two) state_d = STALL;
        STALL:   state_d = RUN;
        HOLD:    state_d = ret_stall_q ? STALL : RUN;
        default: state_d = RUN;
      endcase
    end

    if (rst_n && !hz.hold_req) begin
      case (state_q)
        RUN: begin
          if (need_two || need_one) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write     = 1'b1;
            ifid_write   = 1'b1;
            branch_taken = is_beq && hz.id_equal;
            ifid_flush   = is_beq && hz.id_equal;
          end
        end
        STALL:   idex_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.branch_taken = branch_taken;
  assign hz.state        = state_q;

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] stall_cnt_q, branch_cnt_q;

  // Saturating counters; HOLD forces the strobes low so it never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      if (idex_bubble && stall_cnt_q != '1)   stall_cnt_q  <= stall_cnt_q + CNT_ONE;
      if (branch_taken && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_ONE;
    end
  end

  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.branch_cnt = branch_cnt_q;
`else
  assign hz.stall_cnt  = {STAT_W{1'b0}};
  assign hz.branch_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl: directed sequences, a vector table and a
// randomized run against a stall-budget model. Counter checks follow HAZARD_STATS_EN.
module tb_id_hazard_ctrl;

  localparam int STAT_W = 16;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;

  // Output vector layout: {pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken, state[1:0]}
  localparam logic [6:0] O_ZERO   = 7'b00000_00;
  localparam logic [6:0] O_RUN    = 7'b11000_00;
  localparam logic [6:0] O_BRANCH = 7'b11011_00;
  localparam logic [6:0] O_BUBBLE = 7'b00100_00;
  localparam logic [6:0] O_STALL  = 7'b00100_01;
  localparam logic [6:0] O_HOLD   = 7'b00000_10;

  typedef struct {
    logic       id_valid;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       eq;
    logic       ex_mr;
    logic       ex_rw;
    logic [4:0] ex_dst;
    logic       mem_mr;
    logic [4:0] mem_dst;
    logic       hold;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [6:0] exp_out;
    logic [1:0] exp_next;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: a hold flag and a count of owed forced-stall cycles.
  bit   m_hold;
  int   m_pending;
  int   m_stalls;
  int   m_branches;

  id_hazard_ctrl_if #(.STAT_W(STAT_W)) hz ();

  id_hazard_ctrl #(.STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(logic v, logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic eq,
                               logic ex_mr, logic ex_rw, logic [4:0] ex_dst,
                               logic mem_mr, logic [4:0] mem_dst, logic hold);
    stim_t s;
    s.id_valid = v;  s.op = op;  s.rs = rs;  s.rt = rt;  s.eq = eq;
    s.ex_mr = ex_mr; s.ex_rw = ex_rw; s.ex_dst = ex_dst;
    s.mem_mr = mem_mr; s.mem_dst = mem_dst; s.hold = hold;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    hz.id_valid     = s.id_valid;
    hz.id_opcode    = s.op;
    hz.id_rs        = s.rs;
    hz.id_rt        = s.rt;
    hz.id_equal     = s.eq;
    hz.ex_mem_read  = s.ex_mr;
    hz.ex_reg_write = s.ex_rw;
    hz.ex_dst       = s.ex_dst;
    hz.mem_mem_read = s.mem_mr;
    hz.mem_dst      = s.mem_dst;
    hz.hold_req     = s.hold;
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {hz.pc_write, hz.ifid_write, hz.idex_bubble, hz.ifid_flush, hz.branch_taken, hz.state};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  function automatic int cnt_exp(int n);
`ifdef HAZARD_STATS_EN
    return (n > (2**STAT_W - 1)) ? (2**STAT_W - 1) : n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkCounters(input string name, input int stalls, input int branches);
    checkValue({name, "_stall_cnt"}, int'(hz.stall_cnt), cnt_exp(stalls));
    checkValue({name, "_branch_cnt"}, int'(hz.branch_cnt), cnt_exp(branches));
  endtask

  // Stall budget straight from the hazard rules, first matching rule wins.
  function automatic int need_of(stim_t s);
    bit use_rs, use_rt, beq, ex_hit, mem_hit;
    use_rt  = s.id_valid && (s.op == OP_R || s.op == OP_SW || s.op == OP_BEQ);
    use_rs  = use_rt || (s.id_valid && s.op == OP_LW);
    beq     = s.id_valid && s.op == OP_BEQ;
    ex_hit  = (use_rs && s.rs != 0 && s.rs == s.ex_dst) || (use_rt && s.rt != 0 && s.rt == s.ex_dst);
    mem_hit = (use_rs && s.rs != 0 && s.rs == s.mem_dst) || (use_rt && s.rt != 0 && s.rt == s.mem_dst);
    if (beq && s.ex_mr && ex_hit) return 2;
    if (s.ex_mr && ex_hit) return 1;
    if (beq && s.ex_rw && ex_hit) return 1;
    if (beq && s.mem_mr && mem_hit) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] model_out(stim_t s);
    logic [1:0] st;
    logic       br;
    st = m_hold ? 2'b10 : (m_pending > 0 ? 2'b01 : 2'b00);
    if (s.hold || m_hold) return {5'b00000, st};
    if (m_pending > 0 || need_of(s) > 0) return {5'b00100, st};
    br = s.id_valid && s.op == OP_BEQ && s.eq;
    return {1'b1, 1'b1, 1'b0, br, br, st};
  endfunction

  task automatic model_edge(input stim_t s, input logic [6:0] o);
    if (o[4]) m_stalls++;
    if (o[2]) m_branches++;
    if (s.hold) m_hold = 1'b1;
    else if (m_hold) m_hold = 1'b0;
    else if (m_pending > 0) m_pending--;
    else if (need_of(s) == 2) m_pending = 1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(mk(0, OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    m_hold = 1'b0; m_pending = 0; m_stalls = 0; m_branches = 0;
  endtask

  stim_t idle, beq_ld, beq_mem, beq_clr;
  vec_t  tbl[$];
  logic [5:0] ops[6];

  initial begin
    idle    = mk(0, OP_R,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    beq_ld  = mk(1, OP_BEQ, 5, 6, 1, 1, 1, 5, 0, 0, 0);
    beq_mem = mk(1, OP_BEQ, 5, 6, 1, 0, 0, 0, 1, 5, 0);
    beq_clr = mk(1, OP_BEQ, 5, 6, 1, 0, 0, 0, 0, 0, 0);
    ops = '{OP_R, OP_BEQ, OP_LW, OP_SW, OP_ADDI, OP_J};

    // Outputs are held low while reset is asserted, whatever the inputs
    applyStimulus(beq_clr);
    #1 checkOutput("in_reset", O_ZERO);
    checkCounters("in_reset", 0, 0);

    // Load-use on an R-type: one bubble, then normal flow
    doReset();
    applyStimulus(mk(1, OP_R, 3, 4, 0, 1, 1, 3, 0, 0, 0));
    #1 checkOutput("loaduse_bubble", O_BUBBLE);
    @(negedge clk);
    applyStimulus(mk(1, OP_R, 3, 4, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("loaduse_resume", O_RUN);

    // Load followed by beq: two bubbles, then the branch resolves
    doReset();
    applyStimulus(beq_ld);
    #1 checkOutput("ldbeq_c1", O_BUBBLE);
    @(negedge clk); applyStimulus(beq_mem);
    #1 checkOutput("ldbeq_c2", O_STALL);
    @(negedge clk); applyStimulus(beq_clr);
    #1 checkOutput("ldbeq_branch", O_BRANCH);
    @(negedge clk); applyStimulus(idle);
    #1 checkOutput("ldbeq_after", O_RUN);
    checkCounters("ldbeq", 2, 1);

    // Hold arriving during the forced stall cycle
    doReset();
    applyStimulus(beq_ld);
    #1 checkOutput("hold_c1", O_BUBBLE);
    @(negedge clk); applyStimulus(mk(1, OP_BEQ, 5, 6, 1, 0, 0, 0, 1, 5, 1));
    #1 checkOutput("hold_forced", 7'b00000_01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) applyStimulus(beq_mem);
      #1 checkOutput($sformatf("hold_cycle%0d", k), O_HOLD);
    end
    @(negedge clk); applyStimulus(mk(1, OP_BEQ, 5, 6, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("hold_return_stall", O_STALL);
    @(negedge clk);
    #1 checkOutput("hold_return_run", O_RUN);
    checkCounters("hold", 2, 0);

    // Asynchronous reset in the middle of a stall
    doReset();
    applyStimulus(beq_ld);
    @(negedge clk); applyStimulus(beq_mem);
    #1 checkOutput("rst_pre", O_STALL);
    #1 rst_n = 1'b0;
    #1 checkOutput("rst_mid_stall", O_ZERO);
    checkCounters("rst_mid_stall", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(mk(1, OP_BEQ, 5, 6, 0, 0, 0, 0, 0, 0, 0));
    #1 checkOutput("rst_release", O_RUN);
    checkCounters("rst_release", 0, 0);

    // Single-cycle decode table, each vector applied from RUN
    tbl.push_back('{"r_rs_load",      mk(1, OP_R,    3, 4, 0, 1, 1, 3, 0, 0, 0), O_BUBBLE, 2'b00});
    tbl.push_back('{"r_rt_load",      mk(1, OP_R,    1, 4, 0, 1, 1, 4, 0, 0, 0), O_BUBBLE, 2'b00});
    tbl.push_back('{"lw_rt_ignored",  mk(1, OP_LW,   1, 4, 0, 1, 1, 4, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"beq_load",       mk(1, OP_BEQ,  5, 6, 1, 1, 1, 5, 0, 0, 0), O_BUBBLE, 2'b01});
    tbl.push_back('{"beq_alu_ex",     mk(1, OP_BEQ,  5, 6, 1, 0, 1, 6, 0, 0, 0), O_BUBBLE, 2'b00});
    tbl.push_back('{"beq_mem_load",   mk(1, OP_BEQ,  5, 6, 1, 0, 0, 0, 1, 5, 0), O_BUBBLE, 2'b00});
    tbl.push_back('{"beq_taken",      mk(1, OP_BEQ,  5, 6, 1, 0, 0, 0, 0, 0, 0), O_BRANCH, 2'b00});
    tbl.push_back('{"beq_not_taken",  mk(1, OP_BEQ,  5, 6, 0, 0, 0, 0, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"zero_reg",       mk(1, OP_R,    0, 0, 0, 1, 1, 0, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"invalid_id",     mk(0, OP_R,    3, 4, 0, 1, 1, 3, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"addi_no_use",    mk(1, OP_ADDI, 3, 4, 0, 1, 1, 3, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"r_alu_ex",       mk(1, OP_R,    3, 4, 0, 0, 1, 3, 0, 0, 0), O_RUN,    2'b00});
    tbl.push_back('{"sw_rt_load",     mk(1, OP_SW,   2, 7, 0, 1, 1, 7, 0, 0, 0), O_BUBBLE, 2'b00});
    tbl.push_back('{"r_mem_load",     mk(1, OP_R,    3, 4, 0, 0, 0, 0, 1, 3, 0), O_RUN,    2'b00});
    tbl.push_back('{"beq_hold",       mk(1, OP_BEQ,  5, 6, 1, 0, 0, 0, 0, 0, 1), O_ZERO,   2'b10});

    doReset();
    foreach (tbl[i]) begin
      logic [6:0] nxt;
      @(negedge clk);
      applyStimulus(tbl[i].s);
      #1 checkOutput(tbl[i].name, tbl[i].exp_out);
      nxt = (tbl[i].exp_next == 2'b01) ? O_STALL : (tbl[i].exp_next == 2'b10) ? O_HOLD : O_RUN;
      @(negedge clk);
      applyStimulus(idle);
      #1 checkOutput({tbl[i].name, "_next"}, nxt);
    end

    // Randomized traffic against the reference model
    doReset();
    for (int n = 0; n < 600; n++) begin
      stim_t      s;
      logic [6:0] exp;
      @(negedge clk);
      s = mk($urandom_range(0, 9) != 0, ops[$urandom_range(0, 5)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 6) == 0);
      applyStimulus(s);
      #1;
      exp = model_out(s);
      checkOutput($sformatf("rand%0d", n), exp);
      checkCounters($sformatf("rand%0d", n), m_stalls, m_branches);
      model_edge(s, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Hazard and stall controller for the ID stage of the 5-stage MIPS-R2000 pipeline. Each cycle it inspects the instruction in ID against the destinations of the instructions in EX and MEM. It generates PC/IF-ID write enables, the ID/EX control bubble and the IF/ID flush for branches resolved in ID, and sequences multi-cycle stalls and external hold requests through a small state machine.

## Interface
- STAT_W, 16, width of the statistics counters (used only when HAZARD_STATS_EN is defined)
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_opcode  in  6  inst[31:26] of the instruction in ID
- id_rs  in  5  inst[25:21]
- id_rt  in  5  inst[20:16]
- id_equal  in  1  register-file comparison result for the instruction in ID
- ex_mem_read  in  1  instruction in EX is a load (M MemRead bit)
- ex_reg_write  in  1  instruction in EX writes a register
- ex_dst  in  5  destination register of the instruction in EX
- mem_mem_read  in  1  instruction in MEM is a load
- mem_dst  in  5  destination register of the instruction in MEM
- hold_req  in  1  external freeze request (memory wait)
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register load enable
- idex_bubble  out  1  force ID/EX control fields (ex, m, wb) to zero
- ifid_flush  out  1  clear IF/ID to NOP on the next edge
- branch_taken  out  1  select branch target for the PC
- state  out  2  FSM state: RUN=00, STALL=01, HOLD=10
- stall_cnt  out  STAT_W  cycles with idex_bubble=1
- branch_cnt  out  STAT_W  taken branches

## Operation
- Source usage by opcode:
  - R-type (000000), sw (101011) and beq (000100) use rs and rt.
  - lw (100011) uses rs only.
  - Other opcodes use neither. id_valid=0 means no use.
- A source "matches" a destination when they are equal and non-zero. $0 never creates a hazard.
- Hazard detection in RUN, evaluated in this order (first hit wins):
  - beq, ex_mem_read, and ex_dst matches: need=2.
  - ex_mem_read and ex_dst matches a used source: need=1.
  - beq, ex_reg_write, !ex_mem_read, and ex_dst matches: need=1.
  - beq, mem_mem_read, and mem_dst matches: need=1.
- Hazard cycle (RUN with a hit): pc_write=0, ifid_write=0, idex_bubble=1, branch_taken=0, ifid_flush=0.
  - need=2: go to STALL for 1 forced cycle.
  - need=1: stay in RUN and re-evaluate next cycle.
- STALL: same outputs as a hazard cycle, with no detection. Next state is RUN.
- RUN without a hazard: pc_write=1, ifid_write=1, idex_bubble=0.
  - If id_valid, opcode=beq and id_equal: branch_taken=1 and ifid_flush=1 for that cycle.
  - Otherwise both are 0.
- HOLD: entered from any state when hold_req=1 at a clock edge. hold_req has highest priority.
  - In HOLD all outputs are 0.
  - The interrupted state (RUN or STALL) is saved in a 1-bit return register.
  - On the first edge with hold_req=0, the FSM returns to the saved state.
  - A pending STALL cycle is neither lost nor duplicated.
- While hold_req=1 in RUN or STALL, before the edge: outputs are forced to the HOLD values combinationally (no update, no bubble, no flush).

## Timing
- Outputs are Mealy: combinational from state and current inputs. They are valid in the same cycle as detection, with no latency.
- State, return register and counters are updated on the rising clk edge.
- Reset (rst_n=0, asynchronous): state=RUN, return=RUN, counters=0. All outputs are held at 0 while rst_n=0.
- First edge after reset release: normal RUN evaluation.
- Reset asserted mid-STALL or mid-HOLD: immediate return to RUN; the pending stall is discarded.
- Load-use followed by beq uses 2 bubble cycles in total; every other hazard uses 1.
- A branch and a hazard together: the hazard wins, and the branch is resolved on the first non-stall cycle.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_cnt increments on every edge where idex_bubble=1.
  - branch_cnt increments on every edge where branch_taken=1.
  - Both saturate at all-ones, are unaffected by HOLD, and are cleared by reset.
- HAZARD_STATS_EN undefined: no counter registers; stall_cnt and branch_cnt are tied to 0.

## Test plan
- R-type in ID (id_rs=3), ex_mem_read=1, ex_dst=3 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Next cycle, with EX cleared, pc_write=1. state stays 00.
- beq in ID (id_rs=5), ex_mem_read=1, ex_dst=5 -> 2 consecutive bubble cycles with state 00 then 01, then back to 00. stall_cnt=2 with HAZARD_STATS_EN.
- beq, id_equal=1, no hazards -> branch_taken=1 and ifid_flush=1 for 1 cycle. branch_cnt=1.
- ex_mem_read=1, ex_dst=0, id_rs=0 -> no stall. pc_write=1.
- hold_req=1 asserted during the STALL cycle for 3 cycles -> state=10 and all outputs 0 for 3 cycles, then state=01 for one bubble cycle, then 00.
- rst_n pulled low mid-STALL -> outputs 0 immediately, state=00. After release: pc_write=1, stall_cnt=0.
